// File: rtl/led_chain_ctrl_pkg.sv
// led_chain_ctrl_pkg: shared FSM encoding and width helper for the LED chain sequencer
package led_chain_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;
    function automatic int width_of(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/led_chain_ctrl_if.sv
// led_chain_ctrl_if: host write port, status flags and driver pins of the LED chain sequencer
interface led_chain_ctrl_if import led_chain_ctrl_pkg::*; #(
    parameter int c_channels = 24,
    parameter int c_bits     = 12
) ();
    logic                             i_wr_en;
    logic [width_of(c_channels)-1:0]  i_wr_addr;
    logic [c_bits-1:0]                i_wr_data;
    logic                             i_swap;
    logic                             o_busy;
    logic                             o_frame_done;
    logic                             o_overrun;
    logic                             o_clk;
    logic                             o_dai;
    logic                             o_lat;
    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_swap,
        input  o_busy, o_frame_done, o_overrun, o_clk, o_dai, o_lat
    );
    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_swap,
        output o_busy, o_frame_done, o_overrun, o_clk, o_dai, o_lat
    );
endinterface

// File: rtl/led_chain_ctrl_tick_gen.sv
// led_tick_gen: refresh prescaler, one-cycle tick every c_freq/c_refresh cycles
module led_tick_gen import led_chain_ctrl_pkg::*; #(
    parameter int c_freq    = 20000000,
    parameter int c_refresh = 100
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);
    localparam int period = c_freq / c_refresh;
    localparam int cw     = width_of(period);
    logic [cw-1:0] cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else begin
            o_tick <= cnt == cw'(period - 1);
            cnt    <= cnt == cw'(period - 1) ? '0 : cnt + cw'(1);
        end
    end
endmodule

// File: rtl/led_chain_ctrl.sv
// led_chain_ctrl: LED driver-chain frame sequencer; LED_DBUF_EN selects double-buffered word memory
module led_chain_ctrl import led_chain_ctrl_pkg::*; #(
    parameter int c_freq     = 20000000,
    parameter int c_refresh  = 100,
    parameter int c_channels = 24,
    parameter int c_bits     = 12,
    parameter int c_sclk_div = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    led_chain_ctrl_if.slave  bus
);
    localparam int aw = width_of(c_channels);
    localparam int bw = width_of(c_bits);
    localparam int dw = width_of(c_sclk_div);
    state_t            state, state_n;
    logic              tick, phase_end, last, wr_ok, overrun;
    logic [aw-1:0]     ch, rd_addr;
    logic [bw-1:0]     bit_idx;
    logic [dw-1:0]     div_cnt;
    logic [c_bits-1:0] shreg, rd_word;

    led_tick_gen #(.c_freq(c_freq), .c_refresh(c_refresh)) u_tick (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_tick(tick)
    );

    assign phase_end = div_cnt == dw'(c_sclk_div - 1);
    assign last      = ch == '0 && bit_idx == '0;
    assign wr_ok     = bus.i_wr_en && bus.i_wr_addr <= aw'(c_channels - 1);
    assign rd_addr   = state == LOAD ? aw'(c_channels - 1) : ch - aw'(1);

`ifdef LED_DBUF_EN
    logic [c_bits-1:0] mem [2][c_channels];
    logic front, pending, swap_now;
    // banks only trade places between frames, right before LOAD
    assign swap_now = tick && state == IDLE && pending;
    assign rd_word  = mem[front][rd_addr];
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            front   <= 1'b0;
            pending <= 1'b0;
            for (int i = 0; i < c_channels; i++) begin
                mem[0][i] <= '0;
                mem[1][i] <= '0;
            end
        end else begin
            if (wr_ok) mem[~front][bus.i_wr_addr] <= bus.i_wr_data;
            if (swap_now) front <= ~front;
            pending <= bus.i_swap | (pending & ~swap_now);
        end
    end
`else
    logic [c_bits-1:0] mem [c_channels];
    logic unused_swap;
    assign unused_swap = bus.i_swap;
    assign rd_word     = mem[rd_addr];
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < c_channels; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[bus.i_wr_addr] <= bus.i_wr_data;
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = tick ? LOAD : IDLE;
            LOAD:     state_n = SHIFT_LO;
            SHIFT_LO: state_n = phase_end ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: state_n = phase_end ? (last ? LATCH : SHIFT_LO) : SHIFT_HI;
            LATCH:    state_n = phase_end ? DONE : LATCH;
            default:  state_n = IDLE;
        endcase
        bus.o_busy       = state inside {LOAD, SHIFT_LO, SHIFT_HI, LATCH};
        bus.o_frame_done = state == DONE;
        bus.o_overrun    = overrun;
        bus.o_clk        = state == SHIFT_HI;
        bus.o_dai        = (state == SHIFT_LO || state == SHIFT_HI) && shreg[c_bits-1];
        bus.o_lat        = state == LATCH;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_cnt <= '0;
            ch      <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            overrun <= 1'b0;
        end else begin
            div_cnt <= state_n != state ? '0 : div_cnt + dw'(1);
            if (tick && state != IDLE) overrun <= 1'b1;
            if (state == LOAD) begin
                ch      <= aw'(c_channels - 1);
                bit_idx <= bw'(c_bits - 1);
                shreg   <= rd_word;
            end else if (state == SHIFT_HI && phase_end) begin
                // data moves on the falling serial clock edge only
                if (bit_idx != '0) begin
                    bit_idx <= bit_idx - bw'(1);
                    shreg   <= shreg << 1;
                end else if (!last) begin
                    ch      <= ch - aw'(1);
                    bit_idx <= bw'(c_bits - 1);
                    shreg   <= rd_word;
                end
            end
        end
    end
endmodule

// File: tb/tb_led_chain_ctrl.sv
// tb_led_chain_ctrl: directed self-checking bench for led_chain_ctrl
module tb_led_chain_ctrl;
    logic clk, rst_n;
    int checks = 0, errors = 0;

    led_chain_ctrl_if #(.c_channels(2), .c_bits(4)) a ();
    led_chain_ctrl_if #(.c_channels(2), .c_bits(4)) b ();

    led_chain_ctrl #(.c_freq(1000), .c_refresh(10), .c_channels(2), .c_bits(4), .c_sclk_div(1))
        dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(a));
    led_chain_ctrl #(.c_freq(100), .c_refresh(10), .c_channels(2), .c_bits(4), .c_sclk_div(1))
        dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outs(input bit sel);
        return sel ? {b.o_busy, b.o_frame_done, b.o_overrun, b.o_clk, b.o_dai, b.o_lat}
                   : {a.o_busy, a.o_frame_done, a.o_overrun, a.o_clk, a.o_dai, a.o_lat};
    endfunction

    task automatic wr(input bit sel, input logic adr, input logic [3:0] d);
        if (sel) begin
            b.i_wr_en = 1'b1; b.i_wr_addr = adr; b.i_wr_data = d;
        end else begin
            a.i_wr_en = 1'b1; a.i_wr_addr = adr; a.i_wr_data = d;
        end
        @(negedge clk);
        a.i_wr_en = 1'b0;
        b.i_wr_en = 1'b0;
    endtask

    // act 1: write ch0=F, ch1=0 during bit 2 of ch1; act 2: pulse swap mid-frame
    task automatic frame(input bit sel, input int act, input logic [7:0] exp_cap,
                         input int exp_wt, input string t);
        logic [5:0] o;
        logic [7:0] cap;
        logic pc, pd;
        int wt, len, nclk, nlat, bad, ph;
        cap = '0; wt = 0; len = 0; nclk = 0; nlat = 0; bad = 0; ph = 0; pc = 0; pd = 0;
        do begin
            @(negedge clk);
            wt++;
            o = outs(sel);
        end while (!o[5] && wt < 400);
        chk({t, "_start"}, 32'(o[5]), 1);
        if (exp_wt >= 0) chk({t, "_wait"}, wt, exp_wt);
        for (int n = 0; n < 60 && len == 0; n++) begin
            if (n > 0) begin
                @(negedge clk);
                o = outs(sel);
            end
            if (o[2] && !pc) begin
                cap = {cap[6:0], o[1]};
                nclk++;
            end
            if (o[2] && pc && o[1] != pd) bad++;
            if (o[0]) nlat++;
            if (o[4]) len = n + 1;
            pc = o[2];
            pd = o[1];
            if (act == 1 && nclk == 1 && ph == 0) begin
                a.i_wr_en = 1'b1; a.i_wr_addr = 1'b0; a.i_wr_data = 4'hF; ph = 1;
            end else if (act == 2 && nclk == 1 && ph == 0) begin
                a.i_swap = 1'b1; ph = 2;
            end else if (ph == 1) begin
                a.i_wr_addr = 1'b1; a.i_wr_data = 4'h0; ph = 2;
            end else if (ph == 2) begin
                a.i_wr_en = 1'b0; a.i_swap = 1'b0; ph = 3;
            end
        end
        chk({t, "_cap"}, cap, exp_cap);
        chk({t, "_nclk"}, nclk, 8);
        chk({t, "_nlat"}, nlat, 1);
        chk({t, "_len"}, len, 19);
        chk({t, "_dai_hi"}, bad, 0);
        @(negedge clk);
        chk({t, "_idle"}, outs(sel) & 6'b110111, 0);
    endtask

    initial begin
        int w;
        rst_n = 1'b0;
        a.i_wr_en = 1'b0; a.i_wr_addr = '0; a.i_wr_data = '0; a.i_swap = 1'b0;
        b.i_wr_en = 1'b0; b.i_wr_addr = '0; b.i_wr_data = '0; b.i_swap = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_a", outs(0), 0);
        chk("rst_b", outs(1), 0);
        rst_n = 1'b1;
        frame(0, 0, 8'h00, 101, "t1");
`ifdef LED_DBUF_EN
        wr(0, 1'b1, 4'h3);
        frame(0, 2, 8'h00, -1, "db_old");
        frame(0, 0, 8'h30, -1, "db_new");
`else
        wr(0, 1'b1, 4'hA);
        wr(0, 1'b0, 4'h5);
        frame(0, 0, 8'hA5, -1, "t2");
        frame(0, 1, 8'hAF, -1, "t3_now");
        frame(0, 0, 8'h0F, -1, "t3_next");
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(a.o_busy && a.o_clk) && w < 400);
        chk("t4_hi", 32'(a.o_clk), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_abort", outs(0), 0);
        rst_n = 1'b1;
        frame(0, 0, 8'h00, 101, "t4_zero");
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr(1, 1'b1, 4'hA);
        wr(1, 1'b0, 4'h5);
        chk("t5_ovr_pre", 32'(b.o_overrun), 0);
`ifdef LED_DBUF_EN
        b.i_swap = 1'b1;
        @(negedge clk);
        b.i_swap = 1'b0;
        frame(1, 0, 8'hA5, 8, "t5");
`else
        frame(1, 0, 8'hA5, 9, "t5");
`endif
        chk("t5_ovr", 32'(b.o_overrun), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
